// File: rtl/downscale_sequencer.sv
// Bilinear downscale sequencer: fetches 4 neighbours, hands them to an interpolator, writes the result.
// Latency is set by mem_gnt / ip_ready / ip_res_valid handshakes; every request holds until granted.
module downscale_sequencer #(
  parameter logic [7:0] DST_BASE  = 8'h80,
  parameter logic [7:0] MMIO_BASE = 8'hF0
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step_pulse,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [15:0] cfg_scale,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  p00,
  output logic [7:0]  p01,
  output logic [7:0]  p10,
  output logic [7:0]  p11,
  output logic [7:0]  fx,
  output logic [7:0]  fy,
  output logic        ip_valid,
  input  logic        ip_ready,
  input  logic [7:0]  ip_res,
  input  logic        ip_res_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, ISSUE, WAIT_RES, WRITE, ADVANCE, FIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] w_q, h_q, s_q, x_acc, y_acc;
  logic [7:0]  out_idx, res_q;
  logic [1:0]  rd_idx;
  logic        cap_q;
  logic [7:0]  x0, y0, x1, y1, sel_x, sel_y, src_addr;
  logic [8:0]  dst_sum;
  logic [16:0] xs, ys;
  logic        x_wrap, y_end, adv_go, err_set, src_bad, dst_bad;

  assign x0 = x_acc[15:8];
  assign y0 = y_acc[15:8];
  // x0 < W always holds, so min(x0+1, W-1) reduces to a clamp at the last column
  assign x1 = (({8'd0, x0} + 16'd1) >= w_q) ? x0 : x0 + 8'd1;
  assign y1 = (({8'd0, y0} + 16'd1) >= h_q) ? y0 : y0 + 8'd1;
  assign sel_x    = rd_idx[0] ? x1 : x0;
  assign sel_y    = rd_idx[1] ? y1 : y0;
  assign src_addr = sel_y * w_q[7:0] + sel_x;
  assign src_bad  = src_addr >= MMIO_BASE;
  assign dst_sum  = {1'b0, DST_BASE} + {1'b0, out_idx};
  assign dst_bad  = dst_sum >= {1'b0, MMIO_BASE};
  assign xs       = {1'b0, x_acc} + {1'b0, s_q};
  assign ys       = {1'b0, y_acc} + {1'b0, s_q};
  assign x_wrap   = xs[16] | ({8'd0, xs[15:8]} >= w_q);
  assign y_end    = ys[16] | ({8'd0, ys[15:8]} >= h_q);
  assign adv_go   = !step_mode || step_pulse;
  assign fx       = x_acc[7:0];
  assign fy       = y_acc[7:0];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    ip_valid  = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = CHECK;
      CHECK: begin
        if (w_q == 16'd0 || h_q == 16'd0 || s_q == 16'd0) begin
          state_d = FIN;
          err_set = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        // cap_q marks the capture cycle; no new request is raised in it
        if (cap_q) begin
          if (rd_idx == 2'd3) state_d = ISSUE;
        end else if (src_bad) begin
          state_d = FIN;
          err_set = 1'b1;
        end else begin
          mem_req  = 1'b1;
          mem_addr = src_addr;
        end
      end
      ISSUE: begin
        ip_valid = 1'b1;
        if (ip_ready) state_d = WAIT_RES;
      end
      WAIT_RES: if (ip_res_valid) state_d = WRITE;
      WRITE: begin
        if (dst_bad) begin
          state_d = FIN;
          err_set = 1'b1;
        end else begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = dst_sum[7:0];
          mem_wdata = res_q;
          if (mem_gnt) state_d = ADVANCE;
        end
      end
      ADVANCE:  if (adv_go) state_d = (x_wrap && y_end) ? FIN : FETCH;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      w_q <= '0; h_q <= '0; s_q <= '0;
      x_acc <= '0; y_acc <= '0; out_idx <= '0; res_q <= '0;
      rd_idx <= '0; cap_q <= 1'b0;
      p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (state_d == FIN && state_q != FIN) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      case (state_q)
        IDLE: if (start) begin
          w_q <= cfg_width; h_q <= cfg_height; s_q <= cfg_scale;
          x_acc <= '0; y_acc <= '0; out_idx <= '0;
          rd_idx <= '0; cap_q <= 1'b0;
          done <= 1'b0; err <= 1'b0; busy <= 1'b1;
        end
        FETCH: begin
          if (cap_q) begin
            case (rd_idx)
              2'd0:    p00 <= mem_rdata;
              2'd1:    p01 <= mem_rdata;
              2'd2:    p10 <= mem_rdata;
              default: p11 <= mem_rdata;
            endcase
            rd_idx <= rd_idx + 2'd1;
            cap_q  <= 1'b0;
          end else if (mem_req && mem_gnt) begin
            cap_q <= 1'b1;
          end
        end
        WAIT_RES: if (ip_res_valid) res_q <= ip_res;
        WRITE:    if (mem_req && mem_gnt) out_idx <= out_idx + 8'd1;
        ADVANCE: if (adv_go) begin
          if (x_wrap) begin
            x_acc <= '0;
            if (!y_end) y_acc <= ys[15:0];
          end else begin
            x_acc <= xs[15:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_downscale_sequencer.sv
// Directed bench for downscale_sequencer: memory and interpolator responders with a scoreboard
// of expected interpolator requests and destination writes built from a reference walk.
module tb_downscale_sequencer;

  logic        clk, aclr, start, step_mode, step_pulse;
  logic [15:0] cfg_width, cfg_height, cfg_scale;
  logic        mem_req, mem_we, mem_gnt;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  p00, p01, p10, p11, fx, fy;
  logic        ip_valid, ip_ready, ip_res_valid;
  logic [7:0]  ip_res;
  logic        busy, done, err;

  typedef struct packed {logic [7:0] p00, p01, p10, p11, fx, fy;} pix_t;
  typedef struct packed {logic [7:0] a, d;} wr_t;

  pix_t       exp_ip[$];
  wr_t        exp_wr[$];
  logic [7:0] img [256];
  int checks = 0, failures = 0;
  int gnt_delay = 0, ip_delay = 0;
  int writes = 0, reads = 0, req_cycles = 0;
  int n_exp_wr = 0;
  bit exp_err = 0;

  downscale_sequencer dut (
    .clk(clk), .aclr(aclr), .start(start), .step_mode(step_mode), .step_pulse(step_pulse),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_scale(cfg_scale),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .p00(p00), .p01(p01), .p10(p10), .p11(p11), .fx(fx), .fy(fy),
    .ip_valid(ip_valid), .ip_ready(ip_ready), .ip_res(ip_res), .ip_res_valid(ip_res_valid),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] interp(input pix_t t);
    return t.p00 + {t.p01[6:0], 1'b0} + t.p10 * 8'd3 + (t.p11 ^ t.fx) + t.fy;
  endfunction

  // Reference walk over the output grid; fills both scoreboard queues.
  task automatic build(input int W, input int H, input int S);
    int xa, ya, idx, x0, y0, x1, y1, ax, ay, a, dst, xs, ys;
    bit fin;
    logic [7:0] pv [4];
    pix_t t;
    exp_err = 0; n_exp_wr = 0; xa = 0; ya = 0; idx = 0; fin = 0;
    if (W == 0 || H == 0 || S == 0) begin exp_err = 1; fin = 1; end
    for (int it = 0; it < 400 && !fin; it++) begin
      x0 = xa >> 8; y0 = ya >> 8;
      x1 = (x0 + 1 < W - 1) ? x0 + 1 : W - 1;
      y1 = (y0 + 1 < H - 1) ? y0 + 1 : H - 1;
      for (int k = 0; k < 4 && !fin; k++) begin
        ax = (k % 2 != 0) ? x1 : x0;
        ay = (k / 2 != 0) ? y1 : y0;
        a  = (ay * W + ax) % 256;
        if (a >= 240) begin exp_err = 1; fin = 1; end
        else pv[k] = img[a];
      end
      if (!fin) begin
        t.p00 = pv[0]; t.p01 = pv[1]; t.p10 = pv[2]; t.p11 = pv[3];
        t.fx = 8'(xa); t.fy = 8'(ya);
        exp_ip.push_back(t);
        dst = 128 + idx;
        if (dst >= 240) begin exp_err = 1; fin = 1; end
        else begin
          exp_wr.push_back('{a: 8'(dst), d: interp(t)});
          n_exp_wr++; idx++;
          xs = xa + S;
          if ((xs >> 16) != 0 || ((xs >> 8) % 256) >= W) begin
            xa = 0; ys = ya + S;
            if ((ys >> 16) != 0 || ((ys >> 8) % 256) >= H) fin = 1;
            else ya = ys;
          end else xa = xs;
        end
      end
    end
  endtask

  // Memory responder: grants after gnt_delay waiting cycles, returns read data the cycle after grant.
  initial begin : mem_resp
    int wcnt; bit have_ref, rd_pend; logic ref_we; logic [7:0] ref_addr, ref_wd, rd_addr; wr_t w;
    mem_gnt = 1'b0; mem_rdata = 8'd0; wcnt = 0; have_ref = 0; rd_pend = 0;
    ref_we = 0; ref_addr = 0; ref_wd = 0; rd_addr = 0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin mem_rdata = img[rd_addr]; rd_pend = 0; end
      if (aclr) begin
        mem_gnt = 1'b0; wcnt = 0; have_ref = 0;
      end else if (mem_req) begin
        req_cycles++;
        if (!have_ref) begin
          ref_we = mem_we; ref_addr = mem_addr; ref_wd = mem_wdata; have_ref = 1;
        end else begin
          chk("mem_hold", {mem_we, mem_addr, mem_wdata}, {ref_we, ref_addr, ref_wd});
        end
        if (wcnt >= gnt_delay) begin
          mem_gnt = 1'b1; wcnt = 0; have_ref = 0;
          if (mem_we) begin
            writes++;
            if (exp_wr.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 16'hFFFF);
            else begin
              w = exp_wr.pop_front();
              chk("write", {mem_addr, mem_wdata}, {w.a, w.d});
            end
          end else begin
            reads++; rd_pend = 1; rd_addr = mem_addr;
          end
        end else begin
          mem_gnt = 1'b0; wcnt++;
        end
      end else begin
        mem_gnt = 1'b0; wcnt = 0; have_ref = 0;
      end
    end
  end

  // Interpolator responder: ready after ip_delay cycles, result one cycle after the transfer.
  initial begin : ip_resp
    int icnt; bit have_ref, res_pend; pix_t ref_t, obs, e; logic [7:0] res_val;
    ip_ready = 1'b0; ip_res_valid = 1'b0; ip_res = 8'd0;
    icnt = 0; have_ref = 0; res_pend = 0; ref_t = '0; res_val = 0;
    forever begin
      @(negedge clk);
      ip_res_valid = 1'b0;
      if (res_pend) begin ip_res_valid = 1'b1; ip_res = res_val; res_pend = 0; end
      obs = {p00, p01, p10, p11, fx, fy};
      if (aclr) begin
        ip_ready = 1'b0; icnt = 0; have_ref = 0; res_pend = 0;
      end else if (ip_valid) begin
        if (!have_ref) begin ref_t = obs; have_ref = 1; end
        else chk("ip_hold", obs, ref_t);
        if (icnt >= ip_delay) begin
          ip_ready = 1'b1; icnt = 0; have_ref = 0;
          if (exp_ip.size() == 0) chk("unexpected_ip", obs, 48'hFFFFFFFFFFFF);
          else begin
            e = exp_ip.pop_front();
            chk("ip_tuple", obs, e);
          end
          res_pend = 1; res_val = interp(obs);
        end else begin
          ip_ready = 1'b0; icnt++;
        end
      end else begin
        ip_ready = 1'b0; icnt = 0; have_ref = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
  endtask

  task automatic set_cfg(input int W, input int H, input int S);
    cfg_width = 16'(W); cfg_height = 16'(H); cfg_scale = 16'(S);
  endtask

  task automatic run_job(input string tag, input int W, input int H, input int S, input int gd, input int id);
    int wbase;
    gnt_delay = gd; ip_delay = id;
    build(W, H, S);
    set_cfg(W, H, S);
    wbase = writes;
    pulse_start();
    wait_done(5000);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_count"}, writes - wbase, n_exp_wr);
    chk({tag, "_queues"}, exp_wr.size() + exp_ip.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {mem_req, mem_we, ip_valid, busy, done, err, mem_addr, mem_wdata, fx, fy}, 0);
    chk({tag, "_pix"}, {p00, p01, p10, p11}, 0);
  endtask

  initial begin : main
    int base, n;
    for (int i = 0; i < 256; i++) img[i] = 8'(i * 29 + 7);
    aclr = 1'b1; start = 1'b0; step_mode = 1'b0; step_pulse = 1'b0;
    set_cfg(0, 0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    aclr = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");

    run_job("basic4x4", 4, 4, 16'h0200, 0, 0);
    run_job("clamp2x2", 2, 2, 16'h0080, 0, 0);

    // zero width: error and done quickly, no memory traffic
    base = req_cycles;
    set_cfg(0, 4, 16'h0200);
    pulse_start();
    repeat (2) @(negedge clk);
    chk("zero_w_err", err, 1);
    chk("zero_w_done", done, 1);
    chk("zero_w_noreq", req_cycles - base, 0);

    run_job("wait_states", 4, 4, 16'h0200, 3, 2);
    run_job("mmio_abort", 16, 16, 16'h0F00, 1, 1);

    // single-step: one write per accepted pulse, stray pulses/starts ignored
    step_mode = 1'b1; gnt_delay = 0; ip_delay = 0;
    build(4, 4, 16'h0200);
    set_cfg(4, 4, 16'h0200);
    base = writes;
    pulse_start();
    n = 0;
    while (writes - base < 1 && n < 300) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("step_first", writes - base, 1);
    chk("step_busy0", busy, 1);
    for (int p = 1; p < 4; p++) begin
      @(negedge clk) step_pulse = 1'b1;
      @(negedge clk) step_pulse = 1'b0;
      repeat (2) @(negedge clk);
      step_pulse = 1'b1; start = 1'b1;
      @(negedge clk) step_pulse = 1'b0; start = 1'b0;
      repeat (30) @(negedge clk);
      chk("step_writes", writes - base, p + 1);
      chk("step_busy", busy, 1);
    end
    @(negedge clk) step_pulse = 1'b1;
    @(negedge clk) step_pulse = 1'b0;
    wait_done(200);
    chk("step_err", err, 0);
    chk("step_queues", exp_wr.size() + exp_ip.size(), 0);
    step_mode = 1'b0;

    // reset in the middle of the second read of the first pixel
    gnt_delay = 3; ip_delay = 0;
    build(4, 4, 16'h0200);
    set_cfg(4, 4, 16'h0200);
    base = reads;
    pulse_start();
    n = 0;
    while (!(reads - base == 1 && mem_req && mem_addr == 8'd1) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("rst_reach_read2", n < 200, 1);
    aclr = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    exp_ip.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    base = req_cycles;
    repeat (5) @(negedge clk);
    chk("rst_idle", {busy, done, err}, 0);
    chk("rst_noreq", req_cycles - base, 0);
    run_job("after_reset", 4, 4, 16'h0200, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/downscale_sequencer.md
DOWNSCALE_SEQUENCER -- requirements
Module: downscale_sequencer

Interface
REQ-001 Parameter DST_BASE, default 8'h80: byte address of output pixel 0.
REQ-002 Parameter MMIO_BASE, default 8'hF0: first address the block never accesses.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port aclr, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: one-cycle start pulse.
REQ-006 Port step_mode and step_pulse, input, 1 each: single-step enable and one-cycle advance pulse.
REQ-007 Port cfg_width and cfg_height, input, 16 each: source image dimensions in pixels.
REQ-008 Port cfg_scale, input, 16: Q8.8 source step per output pixel.
REQ-009 Port mem_req, output, 1: memory access request.
REQ-010 Port mem_we, output, 1: write qualifier for the request.
REQ-011 Port mem_addr, output, 8: access address.
REQ-012 Port mem_wdata, output, 8: write data.
REQ-013 Port mem_gnt, input, 1: grant for the current request.
REQ-014 Port mem_rdata, input, 8: read data.
REQ-015 Port p00, p01, p10, p11, output, 8 each: neighbour pixels.
REQ-016 Port fx and fy, output, 8 each: fractional weights.
REQ-017 Port ip_valid, output, 1; ip_ready, input, 1: interpolator request handshake.
REQ-018 Port ip_res, input, 8; ip_res_valid, input, 1: interpolator result.
REQ-019 Port busy, done and err, output, 1 each: status.

Function
REQ-020 States: IDLE, CHECK, FETCH, ISSUE, WAIT_RES, WRITE, ADVANCE, FIN.
REQ-021 IDLE+start: latch cfg_*, clear x_acc/y_acc/out_idx, clear done/err, set busy, go to CHECK; start outside IDLE is ignored.
REQ-022 CHECK: width, height or scale equal to 0 goes to FIN with err=1 and no memory access; otherwise goes to FETCH.
REQ-023 Coordinates: x0=x_acc[15:8], y0=y_acc[15:8], x1=min(x0+1,W-1), y1=min(y0+1,H-1), fx=x_acc[7:0], fy=y_acc[7:0].
REQ-024 Source address = (y*W + x) truncated to 8 bits.
REQ-025 Any source address >= MMIO_BASE aborts the run to FIN with err=1.
REQ-026 FETCH issues 4 reads in order p00(y0,x0), p01(y0,x1), p10(y1,x0), p11(y1,x1).
REQ-027 Each FETCH read holds mem_req=1, mem_we=0 and a stable mem_addr until mem_gnt is sampled high.
REQ-028 mem_rdata is captured on the cycle after the grant.
REQ-029 The next FETCH request starts no earlier than that capture cycle.
REQ-030 ISSUE drives ip_valid=1 with p**/fx/fy stable until ip_ready is high; transfer completes on that edge, then go to WAIT_RES.
REQ-031 WAIT_RES captures ip_res on ip_res_valid, then goes to WRITE.
REQ-032 WRITE: mem_req=1, mem_we=1, mem_addr=DST_BASE+out_idx, mem_wdata=result, held until mem_gnt; out_idx increments on grant.
REQ-033 If DST_BASE+out_idx >= MMIO_BASE at WRITE, go to FIN with err=1 and perform no write.
REQ-034 ADVANCE x-step: x_acc+=scale (17-bit sum); if new x_acc[15:8] >= W, then x_acc=0 and y_acc+=scale.
REQ-035 ADVANCE termination: if new y_acc[15:8] >= H or the y sum carries out, go to FIN; otherwise go to FETCH.
REQ-036 With step_mode=1, ADVANCE waits for step_pulse and exactly one output pixel is produced per pulse; step_pulse outside ADVANCE is ignored.
REQ-037 FIN: busy=0, done=1 sticky until the next accepted start, then go to IDLE.
REQ-038 mem_req, ip_valid, mem_we are 0 in all other states; at most one memory request is outstanding.

Reset
REQ-039 aclr=1 at any time immediately forces IDLE, including mid-request (mem_req drops without waiting for grant).
REQ-040 Reset values: all outputs 0; x_acc, y_acc, out_idx and all latched pixels 0.
REQ-041 After aclr deasserts, the block waits for a fresh start.

Verification
REQ-042 4x4 image at 0x00-0x0F, scale 0x0200, start -> 4 writes to 0x80-0x83 of pixels (0,0),(0,2),(2,0),(2,2) with fx=fy=0; done=1; err=0.
REQ-043 2x2 image, scale 0x0080 -> 16 outputs; pixel (1,1) fetches with x1=x0=1 and y1=y0=1 (clamp); fx alternates 0x00/0x80.
REQ-044 cfg_width=0, start -> err=1 and done=1 within 3 cycles; mem_req is never asserted.
REQ-045 mem_gnt delayed 3 cycles and ip_ready delayed 2 cycles -> addresses and data stay stable throughout; results are identical to zero-wait.
REQ-046 step_mode=1 -> exactly one write per step_pulse; busy=1 between pulses.
REQ-047 aclr pulse during the second FETCH read -> all outputs 0 next edge; a new start then reproduces the REQ-042 result.
